// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings used by the bus initiator and the slaves.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic {
    HBURST_SINGLE = 1'b0,
    HBURST_INCR   = 1'b1
  } hburst_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Word increment, modulo 2^32, keeping the address word-aligned.
  function automatic logic [31:0] next_word_addr(input logic [31:0] a);
    return {a[31:2] + 30'd1, 2'b00};
  endfunction

endpackage

// File: rtl/ahb_master.sv
// Single-master AHB-lite initiator: turns one command (addr, dir, beats)
// into pipelined NONSEQ/SEQ address phases and their data phases.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int MAX_BEATS = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESTn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [31:0]                  cmd_addr,
  input  logic [$clog2(MAX_BEATS)-1:0] cmd_len,
  input  logic [31:0]                  wdata,
  output logic                         wdata_req,
  output logic [31:0]                  rdata,
  output logic                         rdata_valid,
  output logic                         done,
  output logic                         err,
  output logic [31:0]                  HADDR,
  output logic [1:0]                   HTRANS,
  output logic                         HWRITE,
  output logic [2:0]                   HSIZE,
  output logic                         HBURST,
  output logic [31:0]                  HWDATA,
  input  logic [31:0]                  HRDATA,
  input  logic                         HREADY,
  input  logic                         HRESP
);

  localparam int LW = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_t;

  state_t        state;
  htrans_t       htrans_q;
  hburst_t       hburst_q;
  logic [LW-1:0] cnt;
  logic          dphase;

  // BURST and LAST are exactly the cycles in which a data phase is on the bus.
  assign dphase    = (state == S_BURST) || (state == S_LAST);
  assign cmd_ready = (state == S_IDLE);
  assign wdata_req = (htrans_q != HTRANS_IDLE) && HWRITE;
  assign HTRANS    = htrans_q;
  assign HBURST    = hburst_q;
  assign HSIZE     = HSIZE_WORD;

  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) begin
      state       <= S_IDLE;
      htrans_q    <= HTRANS_IDLE;
      hburst_q    <= HBURST_SINGLE;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HWDATA      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;

      if (HREADY && wdata_req)
        HWDATA <= wdata;

      if (dphase && HREADY && (HRESP == HRESP_OKAY) && !HWRITE) begin
        rdata       <= HRDATA;
        rdata_valid <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state    <= S_ADDR;
            htrans_q <= HTRANS_NONSEQ;
            HADDR    <= cmd_addr & ~32'h3;
            HWRITE   <= cmd_write;
            hburst_q <= (cmd_len != '0) ? HBURST_INCR : HBURST_SINGLE;
            cnt      <= cmd_len;
          end
        end
        S_ADDR, S_BURST: begin
          // First ERROR cycle overrides the HREADY=0 hold: pending address is dropped.
          if ((state == S_BURST) && (HRESP == HRESP_ERROR)) begin
            htrans_q <= HTRANS_IDLE;
            if (HREADY) begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_LAST;
            end
          end else if (HREADY) begin
            if (cnt == '0) begin
              htrans_q <= HTRANS_IDLE;
              state    <= S_LAST;
            end else begin
              cnt      <= cnt - LW'(1);
              HADDR    <= next_word_addr(HADDR);
              htrans_q <= HTRANS_SEQ;
              state    <= S_BURST;
            end
          end
        end
        S_LAST: begin
          if (HREADY) begin
            done  <= 1'b1;
            err   <= (HRESP == HRESP_ERROR);
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master with a simple word-read responder (word i reads i+1).
module tb_ahb_master;

  logic        HCLK = 1'b0;
  logic        HRESTn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wdata, rdata;
  logic        wdata_req, rdata_valid, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HBURST, HREADY, HRESP;
  logic [2:0]  HSIZE;

  int total = 0;
  int bad   = 0;

  logic        dp_valid;
  logic [31:0] dp_addr;
  logic [1:0]  exp_tr [4] = '{2'b10, 2'b11, 2'b11, 2'b11};

  always #5 HCLK = ~HCLK;

  ahb_master #(.MAX_BEATS(16)) dut (
    .HCLK(HCLK), .HRESTn(HRESTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_req(wdata_req), .rdata(rdata), .rdata_valid(rdata_valid),
    .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // Responder data-phase tracking: word index i returns i+1.
  always_ff @(posedge HCLK or negedge HRESTn) begin
    if (!HRESTn) begin
      dp_valid <= 1'b0;
      dp_addr  <= '0;
    end else if (HREADY) begin
      dp_valid <= HTRANS[1];
      dp_addr  <= HADDR;
    end
  end
  assign HRDATA = dp_valid ? ({2'b00, dp_addr[31:2]} + 32'd1) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = len;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " htrans"}, 32'(HTRANS), 32'h0);
    chk({tag, " haddr"}, HADDR, 32'h0);
    chk({tag, " hwrite"}, 32'(HWRITE), 32'h0);
    chk({tag, " hsize"}, 32'(HSIZE), 32'h2);
    chk({tag, " hburst"}, 32'(HBURST), 32'h0);
    chk({tag, " hwdata"}, HWDATA, 32'h0);
    chk({tag, " rdata"}, rdata, 32'h0);
    chk({tag, " outs"}, 32'({rdata_valid, done, err, wdata_req, cmd_ready}), 32'h01);
  endtask

  initial begin
    int nrv, done_at, nacc, errd;
    logic sawc;
    HRESTn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) cyc();
    chk_reset_vals("rst");
    HRESTn = 1'b1;
    cyc();

    // Single zero-wait write
    wdata = 32'hDEADBEEF;
    chk("t1 ready", 32'(cmd_ready), 32'h1);
    issue(1'b1, 32'h4, 4'd0);
    chk("t1 htrans c1", 32'(HTRANS), 32'h2);
    chk("t1 haddr c1", HADDR, 32'h4);
    chk("t1 wreq c1", 32'({HWRITE, wdata_req, HBURST, cmd_ready}), 32'hC);
    cyc();
    chk("t1 htrans c2", 32'(HTRANS), 32'h0);
    chk("t1 hwdata c2", HWDATA, 32'hDEADBEEF);
    chk("t1 done c2", 32'(done), 32'h0);
    cyc();
    chk("t1 done/err c3", 32'({done, err}), 32'h2);

    // 4-beat INCR read, with optional 2-cycle stall on beat 2
    for (int t = 0; t < 2; t++) begin
      issue(1'b0, 32'h0, 4'd3);
      nrv = 0; done_at = 0;
      for (int k = 1; k <= 10; k++) begin
        HREADY = !(t == 1 && (k == 3 || k == 4));
        if (t == 0 && k <= 4) begin
          chk("t2 htrans", 32'(HTRANS), 32'(exp_tr[k-1]));
          chk("t2 haddr", HADDR, 32'(4 * (k - 1)));
          chk("t2 hburst", 32'(HBURST), 32'h1);
        end
        if (t == 1 && k >= 3 && k <= 5) begin
          chk("t3 haddr hold", HADDR, 32'h8);
          chk("t3 htrans hold", 32'(HTRANS), 32'h3);
          chk("t3 hwdata hold", HWDATA, 32'hDEADBEEF);
        end
        if (rdata_valid) begin
          nrv++;
          chk("t23 rdata", rdata, 32'(nrv));
        end
        if (done) done_at = k;
        cyc();
      end
      HREADY = 1'b1;
      chk("t23 rvalid count", 32'(nrv), 32'h4);
      chk("t23 done cycle", 32'(done_at), (t == 0) ? 32'd6 : 32'd8);
    end

    // ERROR on beat 2 of a 4-beat write
    wdata = 32'h11110000;
    issue(1'b1, 32'h0, 4'd3);
    nrv = 0; done_at = 0; nacc = 0; errd = 0; sawc = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      wdata  = 32'h11110000 + 32'(k);
      HRESP  = (k == 3 || k == 4);
      HREADY = (k != 3);
      if (HTRANS != 2'b00 && HREADY) nacc++;
      if (HADDR == 32'hC) sawc = 1'b1;
      if (rdata_valid) nrv++;
      if (done) begin done_at = k; errd = int'(err); end
      if (k == 3) chk("t4 hwdata c3", HWDATA, 32'h11110002);
      if (k == 4) begin
        chk("t4 htrans idle c4", 32'(HTRANS), 32'h0);
        chk("t4 hwdata c4", HWDATA, 32'h11110002);
      end
      cyc();
    end
    HRESP = 1'b0; HREADY = 1'b1;
    chk("t4 accepted beats", 32'(nacc), 32'h2);
    chk("t4 beat4 addr seen", 32'(sawc), 32'h0);
    chk("t4 done cycle", 32'(done_at), 32'd5);
    chk("t4 err with done", 32'(errd), 32'h1);
    chk("t4 no rvalid", 32'(nrv), 32'h0);

    // Reset mid-burst, then a fresh single read
    wdata = 32'h55AA55AA;
    issue(1'b1, 32'h20, 4'd3);
    cyc();
    chk("t5 pre htrans", 32'(HTRANS), 32'h3);
    HRESTn = 1'b0;
    #1;
    chk_reset_vals("t5 async");
    @(negedge HCLK);
    HRESTn = 1'b1;
    issue(1'b0, 32'h8, 4'd0);
    chk("t5 htrans c1", 32'(HTRANS), 32'h2);
    chk("t5 haddr c1", HADDR, 32'h8);
    cyc(); cyc();
    chk("t5 done/rvalid c3", 32'({done, rdata_valid, err}), 32'h6);
    chk("t5 rdata c3", rdata, 32'h3);

    // Back-to-back single read then single write
    issue(1'b0, 32'hC, 4'd0);
    cyc();
    wdata = 32'hCAFEF00D;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_len = 4'd0;
    chk("t6 busy c2", 32'(cmd_ready), 32'h0);
    cyc();
    chk("t6 done+ready c3", 32'({done, cmd_ready, rdata_valid}), 32'h7);
    chk("t6 rdata c3", rdata, 32'h4);
    cyc();
    cmd_valid = 1'b0;
    chk("t6 htrans c4", 32'(HTRANS), 32'h2);
    chk("t6 haddr c4", HADDR, 32'h10);
    cyc();
    chk("t6 hwdata c5", HWDATA, 32'hCAFEF00D);
    cyc();
    chk("t6 done/err c6", 32'({done, err}), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
